uart_tx_controller: RTL

UART_TX_CONTROLLER -- requirements
Module: uart_tx_controller

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_baud_gen.sv | 14 +
 rtl/uart_tx_controller.sv | 81 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, baud divisor table and oversample default for the UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state (8E1 frame); without it the frame is 8N1.
package uart_pkg;
  localparam int OVERSAMPLE_DEF = 16;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  // indexed by baud_select; element 0 is the rightmost entry
  localparam logic [7:0][14:0] BAUD_DIV = {
    15'd54, 15'd109, 15'd163, 15'd326, 15'd651, 15'd1302, 15'd5208, 15'd20833
  };
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: emits a one-cycle tick every div+1 clocks; clear restarts the period.
module uart_baud_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [14:0] div,
  output logic        tick
);
  logic [14:0] cnt;
  assign tick = cnt == div;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (clear || tick) ? '0 : cnt + 15'd1;
endmodule

// File: rtl/uart_tx_controller.sv
// uart_tx_controller: single-byte UART transmitter with selectable baud and abort on Tx_EN low.
// Define UART_TX_PARITY_EN for an even-parity bit (11-bit frame); default is 8N1.
module uart_tx_controller
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       TxD,
  output logic       Tx_BUSY,
  output logic       Tx_DONE
);
  state_t      state, state_n;
  logic [7:0]  data_q;
  logic [14:0] div_q;
  logic [3:0]  tcnt;
  logic [2:0]  bidx;
  logic        tick, accept, bit_end, done_n;
  assign accept  = Tx_WR && Tx_EN && state == IDLE;
  assign bit_end = tick && tcnt == 4'(OVERSAMPLE - 1);
  assign Tx_BUSY = state != IDLE;
  uart_baud_gen u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(accept),
    .div  (div_q),
    .tick (tick)
  );
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    if (!Tx_EN && state != IDLE) state_n = IDLE;
    else if (accept) state_n = START;
    else if (bit_end)
      case (state)
        START:  state_n = DATA;
`ifdef UART_TX_PARITY_EN
        DATA:   state_n = bidx == 3'd7 ? PARITY : DATA;
        PARITY: state_n = STOP;
`else
        DATA:   state_n = bidx == 3'd7 ? STOP : DATA;
`endif
        STOP: begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      Tx_DONE <= 1'b0;
      data_q  <= '0;
      div_q   <= '0;
      tcnt    <= '0;
      bidx    <= '0;
    end else begin
      state   <= state_n;
      Tx_DONE <= done_n;
      if (accept) begin
        data_q <= Tx_DATA;
        div_q  <= BAUD_DIV[baud_select];
      end
      tcnt <= (state == IDLE || bit_end) ? '0 : tick ? tcnt + 4'd1 : tcnt;
      bidx <= state != DATA ? '0 : bit_end ? bidx + 3'd1 : bidx;
    end
  always_comb begin
    TxD = 1'b1;
    if (state == START) TxD = 1'b0;
    else if (state == DATA) TxD = data_q[bidx];
`ifdef UART_TX_PARITY_EN
    else if (state == PARITY) TxD = ^data_q;
`endif
  end
endmodule
